memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 9, meaning word-address width (2^ADDR_BITS 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning extra wait cycles per access when MEM_WAIT_EN is defined; legal range 1..15.
REQ-003 SHALL have port Clock, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port clear, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port Read, input, 1, meaning read request level from datapath.
REQ-006 SHALL have port Write, input, 1, meaning write request level from datapath.
REQ-007 SHALL have port MAR_addr, input, 32, meaning access address from MAR.
REQ-008 SHALL have port MDR_data, input, 32, meaning write data from MDR.
REQ-009 SHALL have port Mdatain, output, 32, meaning registered read data toward the MDR input mux.
REQ-010 SHALL have port Mready, output, 1, meaning one-cycle completion strobe for the current access.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, RESP; clock is single, reset is synchronous active-high, both fixed.
REQ-012 SHALL sample Read/Write only in IDLE; request levels seen in WAIT or RESP are ignored.
REQ-013 SHALL, in IDLE with Read=1, accept a read; Read has priority when Read and Write are both 1, and the write is dropped.
REQ-014 SHALL, in IDLE with Write=1 and Read=0, accept a write.
REQ-015 SHALL capture MAR_addr[ADDR_BITS-1:0] and MDR_data on the accept edge; upper address bits are ignored, so addresses wrap modulo 2^ADDR_BITS.
REQ-016 SHALL leave IDLE to RESP (macro absent) or WAIT (macro present) on the accept edge.
REQ-017 SHALL, in WAIT, count WAIT_CYCLES cycles, then enter RESP.
REQ-018 SHALL assert Mready for exactly one cycle in RESP, then return to IDLE.
REQ-019 SHALL place read data on Mdatain in the same cycle Mready is high, and hold it until the next read's RESP or reset.
REQ-020 SHALL commit write data to the array on the RESP edge; Mdatain is unchanged by writes.
REQ-021 SHALL give read latency (accept edge to Mready cycle) of 1 cycle without MEM_WAIT_EN and 1+WAIT_CYCLES with it.
REQ-022 SHALL re-accept in IDLE on the cycle after RESP if Read/Write remain high (back-to-back); the requester drops its level in the Mready cycle to avoid a repeat.
REQ-023 SHALL return data written at address A to a later read of A (read-after-write), including aliased addresses A+2^ADDR_BITS.

Reset
REQ-024 SHALL, with clear=1 at a rising edge, force IDLE, Mready=0, Mdatain=0, wait counter=0.
REQ-025 SHALL, on reset mid-access, abort the access: a pending write is not committed and no Mready is issued.
REQ-026 SHALL NOT clear memory array contents on reset.

Configuration
REQ-027 SHALL use macro MEM_WAIT_EN: defined inserts the WAIT state with WAIT_CYCLES cycles; undefined omits WAIT and the counter logic entirely, and WAIT_CYCLES is unused.

Structure
REQ-028 SHALL take the FSM state enum and the ADDR_BITS/WAIT_CYCLES defaults from shared package cpu_mem_pkg.
REQ-029 SHALL instantiate one sub-module mem_array: a synchronous 1-write/1-read 32-bit RAM.

Verification
REQ-030 SHALL cover: Write=1, MAR=0x10, MDR=0x0000000A, then Read=1, MAR=0x10 -> Mready pulses once per access, Mdatain=0x0000000A.
REQ-031 SHALL cover: with MEM_WAIT_EN and WAIT_CYCLES=2, Read accepted at edge N -> Mready high in cycle N+3 only; without the macro -> cycle N+1.
REQ-032 SHALL cover: Read=1 and Write=1 together, MAR=0x20, MDR=0xDEADBEEF -> read performed, mem[0x20] unchanged.
REQ-033 SHALL cover: write 0x12345678 to MAR=0x205 (ADDR_BITS=9), then read MAR=0x005 -> Mdatain=0x12345678.
REQ-034 SHALL cover: clear=1 during WAIT of a write to 0x30 -> no Mready, Mdatain=0, later read of 0x30 returns the prior value.
REQ-035 SHALL cover: Read held high across RESP -> a second read is accepted on the cycle after Mready, giving two Mready pulses.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared responder FSM state type and default memory geometry/wait depth
package cpu_mem_pkg;
  localparam int DEF_ADDR_BITS = 9;
  localparam int DEF_WAIT_CYCLES = 2;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: 1-write/1-read synchronous 32-bit RAM (clk, rst clears only rdata, we/waddr/wdata write, re/raddr -> rdata held between reads)
module mem_array #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] r_mem [2**AW];
  always_ff @(posedge clk)
    if (we) r_mem[waddr] <= wdata;
  always_ff @(posedge clk)
    rdata <= rst ? '0 : re ? r_mem[raddr] : rdata;
endmodule

// File: rtl/memory_responder.sv
// memory_responder: IDLE/WAIT/RESP responder over mem_array (in Clock, clear, Read, Write, MAR_addr, MDR_data; out Mdatain, Mready); MEM_WAIT_EN adds WAIT_CYCLES wait states
module memory_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] MAR_addr,
  input  logic [31:0] MDR_data,
  output logic [31:0] Mdatain,
  output logic        Mready
);
  state_t r_state;
  logic r_wr, r_mready;
  logic [ADDR_BITS-1:0] r_addr;
  logic [31:0] r_data;
  logic w_acc, w_re, w_we;
  logic [ADDR_BITS-1:0] w_raddr;
  logic [31-ADDR_BITS:0] w_unused_addr;
  assign w_unused_addr = MAR_addr[31:ADDR_BITS];
  assign w_acc = r_state == IDLE && (Read | Write);
  assign w_we = r_state == RESP && r_wr && !clear;
  assign Mready = r_mready;
  always_ff @(posedge Clock)
    if (w_acc) begin
      r_addr <= MAR_addr[ADDR_BITS-1:0];
      r_data <= MDR_data;
      r_wr <= ~Read;
    end
`ifdef MEM_WAIT_EN
  logic [3:0] r_cnt;
  logic r_rd, w_done;
  assign w_done = r_state == WAIT && r_cnt == 4'(WAIT_CYCLES - 1);
  // the array read fires on the edge entering RESP so the data lands with Mready
  assign w_re = w_done && r_rd && !clear;
  assign w_raddr = r_addr;
  always_ff @(posedge Clock)
    if (clear) begin
      r_state <= IDLE;
      r_mready <= 1'b0;
      r_cnt <= 4'd0;
    end else begin
      r_mready <= w_done;
      r_state <= r_state == IDLE ? (w_acc ? WAIT : IDLE) : r_state == WAIT ? (w_done ? RESP : WAIT) : IDLE;
      r_cnt <= r_state == WAIT ? r_cnt + 4'd1 : 4'd0;
      if (w_acc) r_rd <= Read;
    end
`else
  logic [31:0] w_unused_wait;
  assign w_unused_wait = 32'(WAIT_CYCLES);
  // no wait states: read straight from the live address on the accept edge
  assign w_re = w_acc && Read && !clear;
  assign w_raddr = MAR_addr[ADDR_BITS-1:0];
  always_ff @(posedge Clock)
    if (clear) begin
      r_state <= IDLE;
      r_mready <= 1'b0;
    end else begin
      r_mready <= w_acc;
      r_state <= w_acc ? RESP : IDLE;
    end
`endif
  mem_array #(.AW(ADDR_BITS)) u_mem (
    .clk(Clock),
    .rst(clear),
    .we(w_we),
    .re(w_re),
    .waddr(r_addr),
    .raddr(w_raddr),
    .wdata(r_data),
    .rdata(Mdatain)
  );
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: table-driven scoreboard bench for memory_responder
module tb_memory_responder;
  import cpu_mem_pkg::*;
  localparam int AB = DEF_ADDR_BITS;
`ifdef MEM_WAIT_EN
  localparam int LAT = 1 + DEF_WAIT_CYCLES;
`else
  localparam int LAT = 1;
`endif
  typedef struct {
    logic rd;
    logic wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  logic Clock = 1'b0, clear = 1'b1, Read = 1'b0, Write = 1'b0;
  logic [31:0] MAR_addr = '0, MDR_data = '0, Mdatain;
  logic Mready;
  int checks = 0, errors = 0;
  logic [31:0] sb[$];
  logic [31:0] last_rd = '0;
  vec_t v[13];
  always #5 Clock = ~Clock;
  memory_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(DEF_WAIT_CYCLES)) dut (
    .Clock(Clock),
    .clear(clear),
    .Read(Read),
    .Write(Write),
    .MAR_addr(MAR_addr),
    .MDR_data(MDR_data),
    .Mdatain(Mdatain),
    .Mready(Mready)
  );
  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endfunction
  task automatic access(input vec_t t);
    int lat;
    logic [31:0] e;
    @(negedge Clock);
    Read = t.rd;
    Write = t.wr;
    MAR_addr = t.a;
    MDR_data = t.d;
    if (t.rd) sb.push_back(t.exp);
    @(posedge Clock);
    #1 Read = 1'b0;
    Write = 1'b0;
    lat = 0;
    do begin
      @(negedge Clock);
      lat++;
    end while (!Mready && lat <= 20);
    chk("latency", lat, LAT);
    if (t.rd) begin
      e = sb.size() > 0 ? sb.pop_front() : 32'hxxxxxxxx;
      chk("rdata", Mdatain, e);
      last_rd = e;
    end else chk("wr_keeps_mdatain", Mdatain, last_rd);
    @(negedge Clock);
    chk("mready_one_cycle", Mready, 32'd0);
  endtask
  initial begin
    int n, lat;
    vec_t r30;
    v[0]  = '{1'b0, 1'b1, 32'h10,       32'h0000000A, 32'h0};
    v[1]  = '{1'b1, 1'b0, 32'h10,       32'h0,        32'h0000000A};
    v[2]  = '{1'b0, 1'b1, 32'h20,       32'h11111111, 32'h0};
    v[3]  = '{1'b1, 1'b1, 32'h20,       32'hDEADBEEF, 32'h11111111};
    v[4]  = '{1'b1, 1'b0, 32'h20,       32'h0,        32'h11111111};
    v[5]  = '{1'b0, 1'b1, 32'h205,      32'h12345678, 32'h0};
    v[6]  = '{1'b1, 1'b0, 32'h005,      32'h0,        32'h12345678};
    v[7]  = '{1'b0, 1'b1, 32'h1FF,      32'hCAFEF00D, 32'h0};
    v[8]  = '{1'b1, 1'b0, 32'h3FF,      32'h0,        32'hCAFEF00D};
    v[9]  = '{1'b1, 1'b0, 32'hFFFFFE10, 32'h0,        32'h0000000A};
    v[10] = '{1'b0, 1'b1, 32'h0,        32'h55AA55AA, 32'h0};
    v[11] = '{1'b1, 1'b0, 32'h200,      32'h0,        32'h55AA55AA};
    v[12] = '{1'b0, 1'b1, 32'h30,       32'h0BADF00D, 32'h0};
    r30   = '{1'b1, 1'b0, 32'h30,       32'h0,        32'h0BADF00D};
    repeat (3) @(negedge Clock);
    chk("reset_mready", {31'd0, Mready}, 32'd0);
    chk("reset_mdatain", Mdatain, 32'd0);
    clear = 1'b0;
    for (int i = 0; i < 13; i++) access(v[i]);
    @(negedge Clock);
    Write = 1'b1;
    MAR_addr = 32'h30;
    MDR_data = 32'hFFFFFFFF;
`ifdef MEM_WAIT_EN
    @(posedge Clock);
    #1 Write = 1'b0;
    @(negedge Clock);
    clear = 1'b1;
`else
    clear = 1'b1;
`endif
    @(posedge Clock);
    #1 clear = 1'b0;
    Write = 1'b0;
    n = 0;
    repeat (LAT + 4) begin
      @(negedge Clock);
      if (Mready) n++;
    end
    chk("abort_no_mready", n, 32'd0);
    chk("abort_mdatain", Mdatain, 32'd0);
    last_rd = '0;
    access(r30);
    @(negedge Clock);
    Read = 1'b1;
    MAR_addr = 32'h10;
    sb.push_back(32'h0000000A);
    sb.push_back(32'h0000000A);
    n = 0;
    lat = 0;
    do begin
      @(negedge Clock);
      lat++;
    end while (!Mready && lat <= 20);
    chk("b2b_latency", lat, LAT);
    if (Mready) begin
      n++;
      chk("b2b_first", Mdatain, sb.pop_front());
    end
    @(posedge Clock);
    @(posedge Clock);
    #1 Read = 1'b0;
    repeat (LAT + 4) begin
      @(negedge Clock);
      if (Mready) begin
        n++;
        if (sb.size() > 0) chk("b2b_second", Mdatain, sb.pop_front());
      end
    end
    chk("b2b_pulses", n, 32'd2);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
